jtag_gpio_seq: RTL and testbench
================================

Name: jtag_gpio_seq

Overview:
- Bit-bang JTAG master that sequences the GPIO scan chain from the fabric side.
- Accepts read/write commands for the GPIO data or GPIO config register on a valid/ready interface and generates the TCK/TMS/TDI waveforms.
- Walks the TAP through IR-scan and DR-scan, captures TDO and returns the captured GPIO value on a response handshake.
- Sits between a CPU/register interface and a (real or virtual) TAP that hosts the GPIO chain.

Parameters:
- NR_GPIOS, 1, width of the GPIO value; the DR is NR_GPIOS+1 bits, with the MSB as the update flag.
- IR_LEN, 4, TAP instruction register length in bits.
- GPIO_DATA_IR_CODE, 4'h2, IR opcode that selects the GPIO data chain (IR_LEN bits).
- GPIO_CONFIG_IR_CODE, 4'h3, IR opcode that selects the GPIO config (output-enable) chain (IR_LEN bits).
- TCK_HALF_PERIOD, 2, clk cycles per TCK phase; legal range ≥1.

Ports:
- clk  input  1  block clock.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when valid&ready.
- cmd_config  input  1  0 = GPIO data register, 1 = GPIO config register.
- cmd_write  input  1  1 = update target register, 0 = read-only scan.
- cmd_wdata  input  NR_GPIOS  value to scan in.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  NR_GPIOS  captured register value.
- busy  output  1  high from command accept until response consumed.
- jtag_tck  output  1  generated TCK.
- jtag_tms  output  1  TMS.
- jtag_tdi  output  1  TDI.
- jtag_tdo  input  1  TDO from the TAP.

Behaviour:
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_rdata=0, busy=0.
  - jtag_tck=0, jtag_tms=1, jtag_tdi=0.
  - FSM=IDLE, all counters 0.
- Handshake:
  - Command is accepted on the clk edge where cmd_valid&cmd_ready. Fields are latched on accept.
  - cmd_ready=0 from accept until the rsp handshake completes.
  - rsp_valid and rsp_rdata hold stable until rsp_valid&rsp_ready.
  - cmd_ready returns to 1 on the cycle after the rsp handshake, so there is only one command in flight.
- TCK generation:
  - Each TCK period is a low phase followed by a high phase, each TCK_HALF_PERIOD clk cycles long.
  - TMS and TDI change only on the first clk of a low phase.
  - TDO is sampled on the last clk of a low phase, i.e. the value present just before TCK rises.
  - TCK idles low outside a command.
- TCK period sequence, from Run-Test/Idle; "edge" means rising TCK:
  - SEL_IR: TMS 1,1,0,0 (4 edges) to reach Shift-IR.
  - SHIFT_IR: IR_LEN edges. TDI = opcode, LSB first. TMS=0, except 1 on the last bit.
  - UPD_IR: TMS 1,1,0,0 (Update-IR, Select-DR, Capture-DR, Shift-DR).
  - SHIFT_DR: NR_GPIOS+1 edges. TDI = {cmd_write, cmd_wdata}, LSB first; the MSB is the update flag. TMS=1 on the last bit only.
    - TDO is captured into a shift register LSB first. The first NR_GPIOS captured bits form rsp_rdata.
  - UPD_DR: TMS 1,0 (Update-DR, Run-Test/Idle).
  - RSP: TCK stays low, TMS=0, rsp_valid=1.
- Timing:
  - Total = 10+IR_LEN+NR_GPIOS+1 TCK periods.
  - If the accept is at cycle 0, the first low phase starts at cycle 1.
  - rsp_valid rises at cycle 1 + periods×2×TCK_HALF_PERIOD.
- Read (cmd_write=0): the update flag is 0, so the target register is unchanged. rsp_rdata returns the captured value: GPIO inputs for data, output enables for config.
- Write: rsp_rdata returns the value captured before the write, which allows read-modify-write.
- A cmd_valid asserted while busy is ignored (not accepted). rsp_ready while rsp_valid=0 has no effect.
- Reset mid-command: all outputs go to their reset values on the next clk and the in-flight command is dropped with no response.
  - The TAP state is then undefined. Recovery is only guaranteed with JTAG_GPIO_SEQ_TAP_RESET_EN.

Optional Feature:
- JTAG_GPIO_SEQ_TAP_RESET_EN
- Defined:
  - After reset, the FSM enters TAP_RST before IDLE and issues 5 TCK periods with TMS=1, then 1 period with TMS=0, ending in Run-Test/Idle.
  - cmd_ready=0 and busy=1 during TAP_RST.
  - Every reset, including a mid-command reset, repeats this sequence.
- Undefined: the FSM goes straight to IDLE. The TAP must already be in Run-Test/Idle when the first command is issued.

Test Plan:
- NR_GPIOS=4, IR_LEN=4, TCK_HALF_PERIOD=2, macro off. Read data while the TAP model's gpio_inputs=4'hA, accept at cycle 0 -> rsp_valid at cycle 77, rsp_rdata=4'hA, TMS/TDI/IR bits match the sequence, model gpio_outputs unchanged.
- Write config 4'h5 -> model gpio_outputs_ena=4'h5 after Update-DR. A following config read returns 4'h5; the write's own rsp_rdata is the prior enable value 4'h0.
- Write data 4'h3, then read-only data scan with cmd_wdata=4'hF and write=0 -> model gpio_outputs stays 4'h3.
- Hold rsp_ready=0 for 20 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0, a second cmd_valid is not accepted. After release, cmd_ready=1 one cycle later.
- Assert reset during SHIFT_DR with the macro defined -> the next cycle shows reset output values, then 6 TCK periods with TMS 1,1,1,1,1,0. A subsequent read returns correct data and no stale response appears.
- TCK_HALF_PERIOD=1 -> TCK toggles every clk and TDO is sampled correctly. A back-to-back command accepted the cycle after the rsp handshake completes normally.

Source files
------------

// File: rtl/jtag_gpio_seq.sv
// Bit-bang JTAG master: IR-scans a GPIO opcode, then DR-scans {update_flag, value}.
// Optional build macro JTAG_GPIO_SEQ_TAP_RESET_EN: TMS=1 x5, 0 x1 after every reset.
module jtag_gpio_seq #(
    parameter int                NR_GPIOS            = 1,
    parameter int                IR_LEN              = 4,
    parameter logic [IR_LEN-1:0] GPIO_DATA_IR_CODE   = 4'h2,
    parameter logic [IR_LEN-1:0] GPIO_CONFIG_IR_CODE = 4'h3,
    parameter int                TCK_HALF_PERIOD     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_config,
    input  logic                cmd_write,
    input  logic [NR_GPIOS-1:0] cmd_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [NR_GPIOS-1:0] rsp_rdata,
    output logic                busy,
    output logic                jtag_tck,
    output logic                jtag_tms,
    output logic                jtag_tdi,
    input  logic                jtag_tdo
);

    // state       | meaning
    // S_IDLE      | TAP parked in Run-Test/Idle, waiting for a command
    // S_START     | command latched, first TCK period starts next clk
    // S_SEL_IR    | TMS 1,1,0,0 towards Shift-IR
    // S_SHIFT_IR  | opcode shifted LSB first
    // S_UPD_IR    | TMS 1,1,0,0 through Update-IR to Shift-DR
    // S_SHIFT_DR  | {write, wdata} out, TDO captured in
    // S_UPD_DR    | TMS 1,0 through Update-DR back to Run-Test/Idle
    // S_RSP       | response held until rsp_ready
    // S_RST_START | after reset, TAP reset sequence starts next clk
    // S_TAP_RST   | TMS 1 x5 then 0 x1
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_SEL_IR, S_SHIFT_IR, S_UPD_IR,
        S_SHIFT_DR, S_UPD_DR, S_RSP, S_RST_START, S_TAP_RST
    } state_t;

    localparam int DR_LEN  = NR_GPIOS + 1;
    localparam int MAX_A   = (IR_LEN > DR_LEN) ? IR_LEN : DR_LEN;
    localparam int MAX_LEN = (MAX_A > 6) ? MAX_A : 6;
    localparam int IDXW    = $clog2(MAX_LEN);
    localparam int PHW     = (TCK_HALF_PERIOD > 1) ? $clog2(TCK_HALF_PERIOD) : 1;
    localparam logic [PHW-1:0] PH_LOAD = PHW'(TCK_HALF_PERIOD - 1);

    state_t              state, nxt_state;
    logic [IDXW-1:0]     idx, nxt_idx;
    logic                nxt_tms;
    logic [PHW-1:0]      phase_cnt;
    logic [IR_LEN-1:0]   ir_sh;
    logic [DR_LEN-1:0]   dr_sh;
    logic [NR_GPIOS-1:0] cap_sh;
    logic                launch;

    assign launch = (state == S_START) || (state == S_RST_START);

    // Segment/index of the TCK period that begins at the next period boundary.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx + 1'b1;
        case (state)
            S_START:     begin nxt_state = S_SEL_IR;  nxt_idx = '0; end
            S_RST_START: begin nxt_state = S_TAP_RST; nxt_idx = '0; end
            S_SEL_IR:    if (idx == IDXW'(3))          begin nxt_state = S_SHIFT_IR; nxt_idx = '0; end
            S_SHIFT_IR:  if (idx == IDXW'(IR_LEN - 1)) begin nxt_state = S_UPD_IR;   nxt_idx = '0; end
            S_UPD_IR:    if (idx == IDXW'(3))          begin nxt_state = S_SHIFT_DR; nxt_idx = '0; end
            S_SHIFT_DR:  if (idx == IDXW'(NR_GPIOS))   begin nxt_state = S_UPD_DR;   nxt_idx = '0; end
            S_UPD_DR:    if (idx == IDXW'(1))          begin nxt_state = S_RSP;      nxt_idx = '0; end
            S_TAP_RST:   if (idx == IDXW'(5))          begin nxt_state = S_IDLE;     nxt_idx = '0; end
            default: ;
        endcase
        case (nxt_state)
            S_SEL_IR, S_UPD_IR: nxt_tms = (nxt_idx < IDXW'(2));
            S_SHIFT_IR:         nxt_tms = (nxt_idx == IDXW'(IR_LEN - 1));
            S_SHIFT_DR:         nxt_tms = (nxt_idx == IDXW'(NR_GPIOS));
            S_UPD_DR:           nxt_tms = (nxt_idx == '0);
            S_TAP_RST:          nxt_tms = (nxt_idx != IDXW'(5));
            default:            nxt_tms = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            jtag_tck  <= 1'b0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
            idx       <= '0;
            phase_cnt <= '0;
            ir_sh     <= '0;
            dr_sh     <= '0;
            cap_sh    <= '0;
`ifdef JTAG_GPIO_SEQ_TAP_RESET_EN
            state     <= S_RST_START;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
`else
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        ir_sh     <= cmd_config ? GPIO_CONFIG_IR_CODE : GPIO_DATA_IR_CODE;
                        dr_sh     <= {cmd_write, cmd_wdata};
                        idx       <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    if (launch || (jtag_tck && phase_cnt == '0)) begin
                        // Period boundary: TCK falls, TMS/TDI move to the next period's values.
                        jtag_tck  <= 1'b0;
                        phase_cnt <= PH_LOAD;
                        state     <= nxt_state;
                        idx       <= nxt_idx;
                        jtag_tms  <= nxt_tms;
                        jtag_tdi  <= 1'b0;
                        if (nxt_state == S_SHIFT_IR) begin
                            jtag_tdi <= ir_sh[0];
                            ir_sh    <= ir_sh >> 1;
                        end
                        if (nxt_state == S_SHIFT_DR) begin
                            jtag_tdi <= dr_sh[0];
                            dr_sh    <= dr_sh >> 1;
                        end
                        if (nxt_state == S_RSP) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= cap_sh;
                        end
                        if (nxt_state == S_IDLE) begin
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end else if (phase_cnt != '0) begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end else begin
                        jtag_tck  <= 1'b1;
                        phase_cnt <= PH_LOAD;
                        // Only the first NR_GPIOS bits are data; the captured flag bit is dropped.
                        if (state == S_SHIFT_DR && idx != IDXW'(NR_GPIOS)) begin
                            cap_sh[NR_GPIOS-1] <= jtag_tdo;
                            for (int i = 0; i < NR_GPIOS - 1; i++)
                                cap_sh[i] <= cap_sh[i+1];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_gpio_seq.sv
// Bench for jtag_gpio_seq: two instances (TCK half period 2 and 1), each against a
// behavioural TAP hosting GPIO data/config chains; results checked against a register model.
`timescale 1ns/1ps
module tb_jtag_gpio_seq;
    localparam int         NR      = 4;
    localparam int         IRL     = 4;
    localparam logic [3:0] DATA_IR = 4'h2;
    localparam logic [3:0] CFG_IR  = 4'h3;
    localparam int         PERIODS = 10 + IRL + NR + 1;
`ifdef JTAG_GPIO_SEQ_TAP_RESET_EN
    localparam logic [1:0] RST_RDY_BUSY = 2'b01;
`else
    localparam logic [1:0] RST_RDY_BUSY = 2'b10;
`endif

    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
        T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
    } tap_e;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          cmd_valid [2], cmd_ready [2], cmd_config [2], cmd_write [2];
    logic          rsp_valid [2], rsp_ready [2], busy [2];
    logic          tck [2], tms [2], tdi [2], tdo [2];
    logic [NR-1:0] cmd_wdata [2], rsp_rdata [2];

    jtag_gpio_seq #(.NR_GPIOS(NR), .IR_LEN(IRL), .GPIO_DATA_IR_CODE(DATA_IR),
                    .GPIO_CONFIG_IR_CODE(CFG_IR), .TCK_HALF_PERIOD(2)) u_dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_config(cmd_config[0]), .cmd_write(cmd_write[0]), .cmd_wdata(cmd_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .busy(busy[0]), .jtag_tck(tck[0]), .jtag_tms(tms[0]), .jtag_tdi(tdi[0]),
        .jtag_tdo(tdo[0]));

    jtag_gpio_seq #(.NR_GPIOS(NR), .IR_LEN(IRL), .GPIO_DATA_IR_CODE(DATA_IR),
                    .GPIO_CONFIG_IR_CODE(CFG_IR), .TCK_HALF_PERIOD(1)) u_dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_config(cmd_config[1]), .cmd_write(cmd_write[1]), .cmd_wdata(cmd_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .busy(busy[1]), .jtag_tck(tck[1]), .jtag_tms(tms[1]), .jtag_tdi(tdi[1]),
        .jtag_tdo(tdo[1]));

    // ---------------- TAP model (one per lane, rising TCK detected on clk) ----------------
    int         cyc = 0;
    tap_e       tap_st  [2] = '{T_RTI, T_RTI};
    logic [3:0] tap_ir  [2] = '{4'hF, 4'hF};
    logic [3:0] ir_sr   [2] = '{4'h0, 4'h0};
    logic [4:0] dr_sr   [2] = '{5'h0, 5'h0};
    logic [3:0] tap_out [2] = '{4'h0, 4'h0};
    logic [3:0] tap_ena [2] = '{4'h0, 4'h0};
    logic       tck_d   [2] = '{1'b0, 1'b0};
    int         edge_n  [2] = '{0, 0};
    logic       hist_tms [2][512];
    logic       hist_tdi [2][512];
    logic [3:0] gpio_in [2];

    function automatic tap_e tap_next(input tap_e s, input logic t);
        case (s)
            T_TLR:   return t ? T_TLR   : T_RTI;
            T_RTI:   return t ? T_SELDR : T_RTI;
            T_SELDR: return t ? T_SELIR : T_CAPDR;
            T_CAPDR: return t ? T_EX1DR : T_SHDR;
            T_SHDR:  return t ? T_EX1DR : T_SHDR;
            T_EX1DR: return t ? T_UPDR  : T_PADR;
            T_PADR:  return t ? T_EX2DR : T_PADR;
            T_EX2DR: return t ? T_UPDR  : T_SHDR;
            T_UPDR:  return t ? T_SELDR : T_RTI;
            T_SELIR: return t ? T_TLR   : T_CAPIR;
            T_CAPIR: return t ? T_EX1IR : T_SHIR;
            T_SHIR:  return t ? T_EX1IR : T_SHIR;
            T_EX1IR: return t ? T_UPIR  : T_PAIR;
            T_PAIR:  return t ? T_EX2IR : T_PAIR;
            T_EX2IR: return t ? T_UPIR  : T_SHIR;
            default: return t ? T_SELDR : T_RTI;
        endcase
    endfunction

    always @(posedge clk) begin
        tap_e nxt;
        cyc <= cyc + 1;
        for (int l = 0; l < 2; l++) begin
            tck_d[l] <= tck[l];
            if (tck[l] && !tck_d[l]) begin
                hist_tms[l][edge_n[l] % 512] <= tms[l];
                hist_tdi[l][edge_n[l] % 512] <= tdi[l];
                edge_n[l] <= edge_n[l] + 1;
                case (tap_st[l])
                    T_CAPIR: ir_sr[l] <= 4'b0001;
                    T_SHIR:  ir_sr[l] <= {tdi[l], ir_sr[l][3:1]};
                    T_CAPDR: dr_sr[l] <= {1'b0, (tap_ir[l] == CFG_IR) ? tap_ena[l] : gpio_in[l]};
                    T_SHDR:  dr_sr[l] <= {tdi[l], dr_sr[l][4:1]};
                    default: ;
                endcase
                nxt = tap_next(tap_st[l], tms[l]);
                tap_st[l] <= nxt;
                if (nxt == T_UPIR) tap_ir[l] <= ir_sr[l];
                if (nxt == T_TLR)  tap_ir[l] <= 4'hF;
                if (nxt == T_UPDR && dr_sr[l][4]) begin
                    if (tap_ir[l] == DATA_IR)     tap_out[l] <= dr_sr[l][3:0];
                    else if (tap_ir[l] == CFG_IR) tap_ena[l] <= dr_sr[l][3:0];
                end
            end
        end
    end

    assign tdo[0] = (tap_st[0] == T_SHDR) ? dr_sr[0][0] : 1'b0;
    assign tdo[1] = (tap_st[1] == T_SHDR) ? dr_sr[1][0] : 1'b0;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] ref_out [2];
    logic [3:0] ref_ena [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at a negedge right after the response handshake.
    task automatic run_cmd(input int l, input logic cfg, input logic wr,
                           input logic [3:0] wd, input int hold);
        int          hp     = (l == 0) ? 2 : 1;
        logic [3:0]  code   = cfg ? CFG_IR : DATA_IR;
        logic [4:0]  dw     = {wr, wd};
        logic [3:0]  exp_rd = cfg ? ref_ena[l] : gpio_in[l];
        logic [63:0] exp_tms, got_tms;
        logic [3:0]  got_ir;
        logic [4:0]  got_dr;
        logic        stable, quiet;
        int          acc, e0, t;
        cmd_valid[l] = 1'b1; cmd_config[l] = cfg; cmd_write[l] = wr; cmd_wdata[l] = wd;
        t = 0;
        while (!cmd_ready[l] && t < 300) begin @(negedge clk); t++; end
        chk("accept_wait", t, 0);
        acc = cyc + 1;
        e0  = edge_n[l];
        @(negedge clk);
        cmd_valid[l] = 1'b0; cmd_wdata[l] = 4'($urandom); cmd_write[l] = 1'($urandom);
        chk("busy_after_accept", {cmd_ready[l], busy[l]}, 2'b01);
        t = 0;
        while (!rsp_valid[l] && t < 1000) begin @(negedge clk); t++; end
        chk("rsp_cycle", cyc, acc + 1 + PERIODS * 2 * hp);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            cmd_valid[l] = (i >= 5 && i < 10);
            @(negedge clk);
            stable &= rsp_valid[l] && (rsp_rdata[l] == exp_rd) && !cmd_ready[l] && busy[l];
        end
        cmd_valid[l] = 1'b0;
        if (hold > 0) chk("hold_stable", stable, 1);
        chk("rsp_rdata", rsp_rdata[l], exp_rd);
        rsp_ready[l] = 1'b1;
        @(negedge clk);
        rsp_ready[l] = 1'b0;
        chk("post_rsp", {rsp_valid[l], cmd_ready[l], busy[l]}, 3'b010);

        exp_tms = '0;
        exp_tms[0] = 1'b1; exp_tms[1] = 1'b1; exp_tms[4+IRL-1] = 1'b1;
        exp_tms[4+IRL] = 1'b1; exp_tms[5+IRL] = 1'b1;
        exp_tms[8+IRL+NR] = 1'b1; exp_tms[9+IRL+NR] = 1'b1;
        got_tms = '0;
        for (int i = 0; i < PERIODS; i++) got_tms[i] = hist_tms[l][(e0 + i) % 512];
        for (int i = 0; i < IRL; i++)    got_ir[i]  = hist_tdi[l][(e0 + 4 + i) % 512];
        for (int i = 0; i < NR + 1; i++) got_dr[i]  = hist_tdi[l][(e0 + 8 + IRL + i) % 512];
        chk("tck_edges", edge_n[l] - e0, PERIODS);
        chk("tms_seq", got_tms, exp_tms);
        chk("ir_tdi", got_ir, code);
        chk("dr_tdi", got_dr, dw);
        chk("tap_ir", tap_ir[l], code);
        chk("tap_state", tap_st[l], T_RTI);
        if (wr) begin
            if (cfg) ref_ena[l] = wd;
            else     ref_out[l] = wd;
        end
        chk("gpio_out", tap_out[l], ref_out[l]);
        chk("gpio_ena", tap_ena[l], ref_ena[l]);
        if (hold > 0) begin
            quiet = 1'b1;
            repeat (4) begin
                @(negedge clk);
                quiet &= !tck[l] && cmd_ready[l] && !rsp_valid[l];
            end
            chk("no_second_cmd", quiet, 1);
        end
    endtask

    task automatic rand_cmds(input int l, input int n);
        for (int i = 0; i < n; i++) begin
            gpio_in[l] = 4'($urandom);
            run_cmd(l, 1'($urandom), 1'($urandom), 4'($urandom), 0);
        end
    endtask

    initial begin
        int t, e0;
        logic [5:0] got6;
        logic no_stale;
        reset = 1'b1;
        for (int l = 0; l < 2; l++) begin
            cmd_valid[l] = 1'b0; cmd_config[l] = 1'b0; cmd_write[l] = 1'b0;
            cmd_wdata[l] = '0; rsp_ready[l] = 1'b0; gpio_in[l] = 4'h0;
            ref_out[l] = 4'h0; ref_ena[l] = 4'h0;
        end
        repeat (3) @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            chk("rst_ready_busy", {cmd_ready[l], busy[l]}, RST_RDY_BUSY);
            chk("rst_rsp", {rsp_valid[l], rsp_rdata[l]}, 5'h00);
            chk("rst_jtag", {tck[l], tms[l], tdi[l]}, 3'b010);
        end
        reset = 1'b0;
`ifdef JTAG_GPIO_SEQ_TAP_RESET_EN
        t = 0;
        while (!(cmd_ready[0] && cmd_ready[1]) && t < 500) begin @(negedge clk); t++; end
        chk("tap_rst_done", cmd_ready[0] && cmd_ready[1], 1);
        chk("tap_rst_edges", edge_n[0], 6);
`endif
        // lane 0: half period 2
        gpio_in[0] = 4'hA;
        run_cmd(0, 1'b0, 1'b0, 4'h0, 0);
        run_cmd(0, 1'b1, 1'b1, 4'h5, 0);
        run_cmd(0, 1'b1, 1'b0, 4'($urandom), 0);
        run_cmd(0, 1'b0, 1'b1, 4'h3, 0);
        gpio_in[0] = 4'h6;
        run_cmd(0, 1'b0, 1'b0, 4'hF, 0);
        gpio_in[0] = 4'h9;
        run_cmd(0, 1'b0, 1'b0, 4'($urandom), 20);
        rand_cmds(0, 6);
        // lane 1: half period 1, back-to-back commands
        gpio_in[1] = 4'hC;
        run_cmd(1, 1'b0, 1'b0, 4'h0, 0);
        run_cmd(1, 1'b1, 1'b1, 4'hE, 0);
        run_cmd(1, 1'b1, 1'b0, 4'h0, 0);
        rand_cmds(1, 4);
`ifdef JTAG_GPIO_SEQ_TAP_RESET_EN
        // reset while lane 0 is in the middle of its DR shift
        cmd_valid[0] = 1'b1; cmd_config[0] = 1'b0; cmd_write[0] = 1'b1; cmd_wdata[0] = 4'hC;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        t = 0;
        while (tap_st[0] != T_SHDR && t < 500) begin @(negedge clk); t++; end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_jtag", {tck[0], tms[0], tdi[0]}, 3'b010);
        chk("midrst_hs", {rsp_valid[0], cmd_ready[0], busy[0]}, 3'b001);
        e0 = edge_n[0];
        no_stale = 1'b1;
        t = 0;
        while (!(cmd_ready[0] && cmd_ready[1]) && t < 500) begin
            @(negedge clk); t++;
            no_stale &= !rsp_valid[0];
        end
        chk("midrst_recover", cmd_ready[0], 1);
        chk("midrst_no_stale", no_stale, 1);
        chk("midrst_edges", edge_n[0] - e0, 6);
        for (int i = 0; i < 6; i++) got6[i] = hist_tms[0][(e0 + i) % 512];
        chk("midrst_tms", got6, 6'b011111);
        chk("midrst_gpio_out", tap_out[0], ref_out[0]);
        gpio_in[0] = 4'h5;
        run_cmd(0, 1'b0, 1'b0, 4'h0, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
